// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8 data bits, LSB first, 1 stop) feeding a first-word-fall-through byte FIFO.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; rx_i async serial input; clk_div_i clocks per bit (<4 -> 4);
// rx_data_o/rx_valid_o/rx_ready_i FIFO head handshake; fifo_count_o occupancy; frame_err_o/overrun_o/parity_err_o sticky
// flags cleared by clear_i. Define UART_RX_PARITY_EN for an even-parity bit before the stop bit (adds parity_err_o).
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             rx_i,
  input  logic [15:0]      clk_div_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  input  logic             clear_i
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic rx_m, rx_s, rx_d;
  logic [15:0] div, tmr;
  logic [2:0] idx;
  logic [7:0] shift;
  logic tick, push, pop, full, empty, wr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CNT_W-1:0] count;
  logic frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  assign parity_err_o = parity_err;
`endif
  assign div = (clk_div_i < 16'd4) ? 16'd4 : clk_div_i;
  assign tick = tmr == 16'd0;
  assign push = state == STOP && tick && rx_s;
  // Timer loads are one less than the wanted interval because the tick cycle itself counts.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      state <= IDLE;
      tmr <= 16'd0;
      idx <= 3'd0;
      shift <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
      frame_err <= (state == STOP && tick && !rx_s) || (frame_err && !clear_i);
`ifdef UART_RX_PARITY_EN
      parity_err <= (state == PARITY && tick && (^shift ^ rx_s)) || (parity_err && !clear_i);
`endif
      tmr <= tick ? tmr : tmr - 16'd1;
      case (state)
        IDLE:
          if (rx_d && !rx_s) begin
            tmr <= (div >> 1) - 16'd1;
            state <= START;
          end
        START:
          if (tick) begin
            tmr <= div - 16'd1;
            idx <= 3'd0;
            state <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (tick) begin
            shift[idx] <= rx_s;
            idx <= idx + 3'd1;
            tmr <= div - 16'd1;
            if (idx == 3'd7)
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end
        PARITY:
          if (tick) begin
            tmr <= div - 16'd1;
            state <= STOP;
          end
        STOP:
          if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = rx_ready_i && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign wr = push && (!full || pop);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr) begin
        mem[wp] <= shift;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(pop);
      overrun <= (push && full && !pop) || (overrun && !clear_i);
    end
  end
  assign rx_data_o = mem[rp];
  assign rx_valid_o = !empty;
  assign fifo_count_o = count;
  assign frame_err_o = frame_err;
  assign overrun_o = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven bench for uart_rx_fifo.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst, rx, ready, clear;
  logic [15:0] div;
  logic [7:0] data;
  logic valid, ferr, ovr;
  logic [3:0] cnt;
`ifdef UART_RX_PARITY_EN
  logic perr;
  logic par_bad;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_rx_fifo dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .rx_i(rx),
    .clk_div_i(div),
    .rx_data_o(data),
    .rx_valid_o(valid),
    .rx_ready_i(ready),
    .fifo_count_o(cnt),
    .frame_err_o(ferr),
    .overrun_o(ovr),
    .clear_i(clear)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(perr)
`endif
  );
  typedef struct {
    logic [15:0] div;
    int bt;
    logic [7:0] d;
    logic stop;
    logic [3:0] exp_cnt;
    logic exp_ferr;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int bt);
    rx = 1'b0;
    cyc(bt);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(bt);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d ^ par_bad;
    cyc(bt);
`endif
    rx = stop;
    cyc(bt);
    rx = 1'b1;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask
  task automatic pop_one();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask
  initial begin
    int n;
    logic [7:0] seen;
    logic [7:0] exp_b;
    vecs[0] = '{16'd16, 16, 8'h55, 1'b1, 4'd1, 1'b0};
    vecs[1] = '{16'd16, 16, 8'hA3, 1'b1, 4'd1, 1'b0};
    vecs[2] = '{16'd16, 16, 8'hA3, 1'b0, 4'd0, 1'b1};
    vecs[3] = '{16'd4, 4, 8'h81, 1'b1, 4'd1, 1'b0};
    vecs[4] = '{16'd2, 4, 8'h3C, 1'b1, 4'd1, 1'b0};
    vecs[5] = '{16'd0, 4, 8'hFF, 1'b1, 4'd1, 1'b0};
    vecs[6] = '{16'd5, 5, 8'h96, 1'b1, 4'd1, 1'b0};
    vecs[7] = '{16'd20, 20, 8'h00, 1'b1, 4'd1, 1'b0};
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    clear = 1'b0;
    div = 16'd16;
`ifdef UART_RX_PARITY_EN
    par_bad = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_count", cnt, 0);
    chk("reset_data", data, 8'h00);
    chk("reset_ferr", ferr, 0);
    chk("reset_ovr", ovr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(4);
    foreach (vecs[v]) begin
      div = vecs[v].div;
      send(vecs[v].d, vecs[v].stop, vecs[v].bt);
      cyc(2 * vecs[v].bt);
      @(negedge clk);
      chk($sformatf("vec%0d_count", v), cnt, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_valid", v), valid, vecs[v].exp_cnt != 0);
      chk($sformatf("vec%0d_ferr", v), ferr, vecs[v].exp_ferr);
      if (vecs[v].exp_cnt != 0) chk($sformatf("vec%0d_data", v), data, vecs[v].d);
      cyc(1);
      pop_one();
      pulse_clear();
    end
    div = 16'd16;
    ready = 1'b1;
    n = 0;
    seen = 8'h00;
    fork
      send(8'h55, 1'b1, 16);
      begin
        for (n = 0; n <= 164; n++) begin
          @(negedge clk);
          if (valid) break;
        end
        seen = data;
      end
    join
    chk("lat_within_bound", n <= 164, 1);
    chk("lat_data", seen, 8'h55);
    cyc(1);
    @(negedge clk);
    chk("lat_drained", cnt, 0);
    ready = 1'b0;
    cyc(32);
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(40);
    @(negedge clk);
    chk("glitch_count", cnt, 0);
    chk("glitch_ferr", ferr, 0);
    cyc(1);
    send(8'hA3, 1'b1, 16);
    cyc(8);
    @(negedge clk);
    chk("after_glitch_count", cnt, 1);
    chk("after_glitch_data", data, 8'hA3);
    cyc(1);
    pop_one();
    cyc(16);
    send(8'hA3, 1'b0, 16);
    cyc(32);
    @(negedge clk);
    chk("stop0_ferr", ferr, 1);
    chk("stop0_count", cnt, 0);
    cyc(1);
    pulse_clear();
    @(negedge clk);
    chk("stop0_cleared", ferr, 0);
    cyc(1);
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 1'b1, 16);
      cyc(16);
    end
    @(negedge clk);
    chk("full_count", cnt, 8);
    chk("full_ovr", ovr, 1);
    chk("full_head", data, 8'h00);
    cyc(1);
    pulse_clear();
    @(negedge clk);
    chk("ovr_cleared", ovr, 0);
    cyc(1);
    fork
      send(8'h99, 1'b1, 16);
      begin
        cyc(153);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
      end
    join
    cyc(16);
    @(negedge clk);
    chk("pushpop_count", cnt, 8);
    chk("pushpop_ovr", ovr, 0);
    cyc(1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h99 : 8'(i + 1);
      @(negedge clk);
      chk($sformatf("pop%0d_data", i), data, exp_b);
      @(posedge clk);
    end
    #1 ready = 1'b0;
    @(negedge clk);
    chk("drained_count", cnt, 0);
    chk("drained_valid", valid, 0);
    cyc(1);
    rx = 1'b0;
    cyc(16);
    rx = 1'b0;
    cyc(16);
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(8);
    rst = 1'b1;
    rx = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(200);
    send(8'h7E, 1'b1, 16);
    cyc(16);
    @(negedge clk);
    chk("rst_mid_count", cnt, 1);
    chk("rst_mid_data", data, 8'h7E);
    chk("rst_mid_ferr", ferr, 0);
    chk("rst_mid_ovr", ovr, 0);
    cyc(1);
    pop_one();
`ifdef UART_RX_PARITY_EN
    cyc(16);
    par_bad = 1'b1;
    send(8'h07, 1'b1, 16);
    cyc(16);
    @(negedge clk);
    chk("par_bad_err", perr, 1);
    chk("par_bad_count", cnt, 1);
    chk("par_bad_data", data, 8'h07);
    cyc(1);
    pop_one();
    pulse_clear();
    par_bad = 1'b0;
    send(8'h07, 1'b1, 16);
    cyc(16);
    @(negedge clk);
    chk("par_ok_err", perr, 0);
    chk("par_ok_data", data, 8'h07);
    cyc(1);
    pop_one();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
